// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package riscv_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: hold, sequential advance, or redirect target.
module fetch_pc_next
    import riscv_pkg::*;
#(
    parameter int AWIDTH = 32
) (
    input  pc_sel_e           sel,
    input  logic [AWIDTH-1:0] pc,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [AWIDTH-1:0] pc_plus4,
    output logic [AWIDTH-1:0] pc_next
);

    // Wraps naturally modulo 2^AWIDTH.
    assign pc_plus4 = pc + AWIDTH'(4);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:   pc_next = pc_plus4;
            PC_REDIR: pc_next = redirect_pc;
            default:  pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and run/halt control.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                AWIDTH     = 32,
    parameter int                IWIDTH     = 32,
    parameter logic [AWIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned       IMEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [IWIDTH-1:0] imem_inst,
    output logic              ifid_valid,
    output logic [AWIDTH-1:0] ifid_pc,
    output logic [AWIDTH-1:0] ifid_pc4,
    output logic [IWIDTH-1:0] ifid_inst,
    output logic              halted,
    output logic              fault
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(IMEM_BYTES - 4);
    localparam logic [IWIDTH-1:0] NOP_W     = IWIDTH'(NOP);
    localparam logic [IWIDTH-1:0] EBREAK_W  = IWIDTH'(EBREAK);

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d, pc_plus4;
    pc_sel_e           pc_sel;
    logic              ifid_valid_q, ifid_valid_d;
    logic [AWIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [AWIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [IWIDTH-1:0] ifid_inst_q, ifid_inst_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              bad_pc;
    logic              ebreak_held;

    fetch_pc_next #(.AWIDTH(AWIDTH)) u_pc_next (
        .sel         (pc_sel),
        .pc          (pc_q),
        .redirect_pc (redirect_pc),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_d)
    );

    assign bad_pc      = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);
    // An accepted EBREAK sitting in IF/ID halts the stage one cycle after it was fetched.
    assign ebreak_held = ifid_valid_q && (ifid_inst_q == EBREAK_W);

    always_comb begin
        state_d      = state_q;
        pc_sel       = PC_HOLD;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_inst_d  = ifid_inst_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        case (state_q)
            FETCH_IDLE: begin
                if (start) begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (redirect_valid) begin
                    // The target is checked for faults on the cycle it is fetched.
                    pc_sel       = PC_REDIR;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_W;
                end else if (flush) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_W;
                    pc_sel       = stall ? PC_HOLD : PC_INC;
                end else if (ebreak_held) begin
                    state_d      = FETCH_HALT;
                    halted_d     = 1'b1;
                    ifid_valid_d = 1'b0;
                end else if (bad_pc) begin
                    state_d      = FETCH_HALT;
                    halted_d     = 1'b1;
                    fault_d      = 1'b1;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_sel       = PC_INC;
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_inst_d  = imem_inst;
                end
            end
            FETCH_HALT: begin
                ifid_valid_d = 1'b0;
                halted_d     = 1'b1;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_inst_q  <= NOP_W;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_inst_q  <= ifid_inst_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_inst  = ifid_inst_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a byte-addressed big-endian memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_inst;
    logic        ifid_valid, halted, fault;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst;
    logic [7:0]  mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(
        .AWIDTH(32), .IWIDTH(32), .RESET_PC(32'h0), .IMEM_BYTES(1024)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_inst(ifid_inst), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_inst = 32'h0;
        if (imem_addr <= 32'd1020)
            imem_inst = {mem[imem_addr], mem[imem_addr + 1], mem[imem_addr + 2], mem[imem_addr + 3]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},   imem_addr,          32'h0);
        chk({tag, "_valid"},  {31'b0, ifid_valid}, 32'h0);
        chk({tag, "_inst"},   ifid_inst,          32'h0000_0013);
        chk({tag, "_pc"},     ifid_pc,            32'h0);
        chk({tag, "_pc4"},    ifid_pc4,           32'h0);
        chk({tag, "_halted"}, {31'b0, halted},    32'h0);
        chk({tag, "_fault"},  {31'b0, fault},     32'h0);
    endtask

    task automatic restart();
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state, then EBREAK program.
        tick();
        chk_reset("reset");
        $display("reset applied");
        rst = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'h50; mem[2] = 8'h00; mem[3] = 8'h93;
        mem[4] = 8'h00; mem[5] = 8'h10; mem[6] = 8'h00; mem[7] = 8'h73;
        start = 1'b1; tick(); start = 1'b0;
        chk("idle_to_run_valid", {31'b0, ifid_valid}, 32'h0);
        tick();
        chk("f0_inst", ifid_inst, 32'h0050_0093);
        chk("f0_pc", ifid_pc, 32'h0);
        chk("f0_pc4", ifid_pc4, 32'h4);
        chk("f0_valid", {31'b0, ifid_valid}, 32'h1);
        tick();
        chk("f1_inst", ifid_inst, 32'h0010_0073);
        chk("f1_pc", ifid_pc, 32'h4);
        chk("f1_halted", {31'b0, halted}, 32'h0);
        tick();
        chk("ebreak_halted", {31'b0, halted}, 32'h1);
        chk("ebreak_valid", {31'b0, ifid_valid}, 32'h0);
        chk("ebreak_fault", {31'b0, fault}, 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        chk("halt_pc_frozen", imem_addr, 32'h8);
        chk("halt_sticky", {31'b0, halted}, 32'h1);
        $display("ebreak program: halted=%0d", halted);

        // Stall for three cycles at pc=8.
        for (int i = 0; i < 8; i++) mem[i] = i[7:0];
        restart();
        tick(); tick();
        chk("pre_stall_addr", imem_addr, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_ifid_pc", ifid_pc, 32'h4);
            chk("stall_ifid_inst", ifid_inst, 32'h0405_0607);
        end
        stall = 1'b0; tick();
        chk("unstall_ifid_pc", ifid_pc, 32'h8);
        chk("unstall_ifid_inst", ifid_inst, 32'h0809_0a0b);
        $display("stall sequence: ifid_pc=%h", ifid_pc);

        // Redirect wins over stall.
        redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1; tick();
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
        chk("redir_inst", ifid_inst, 32'h0000_0013);
        redirect_valid = 1'b0; stall = 1'b0; tick();
        chk("redir_ifid_pc", ifid_pc, 32'h40);
        chk("redir_ifid_inst", ifid_inst, 32'h4041_4243);
        chk("redir_ifid_valid", {31'b0, ifid_valid}, 32'h1);
        $display("redirect to 0x40: ifid_pc=%h", ifid_pc);

        // Flush together with stall at pc=0x10.
        redirect_valid = 1'b1; redirect_pc = 32'h10; tick();
        redirect_valid = 1'b0; tick();
        chk("pre_flush_ifid_pc", ifid_pc, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h10; tick();
        redirect_valid = 1'b0;
        flush = 1'b1; stall = 1'b1; tick();
        chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
        chk("flush_inst", ifid_inst, 32'h0000_0013);
        chk("flush_addr", imem_addr, 32'h10);
        flush = 1'b1; stall = 1'b0; tick();
        chk("flush_adv_addr", imem_addr, 32'h14);
        flush = 1'b0; tick();
        chk("post_flush_ifid_pc", ifid_pc, 32'h14);
        $display("flush+stall: pc held at 0x10");

        // Reset mid-redirect and mid-stall at pc=0x20.
        redirect_valid = 1'b1; redirect_pc = 32'h20; tick();
        redirect_valid = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h20);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1; tick();
        chk_reset("run_rst");
        rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0; tick(); tick();
        chk("idle_ignores_addr", imem_addr, 32'h0);
        chk("idle_ignores_valid", {31'b0, ifid_valid}, 32'h0);
        $display("reset in RUN returns to IDLE");

        // Misaligned redirect target faults on its fetch cycle.
        start = 1'b1; tick(); start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h42; tick();
        redirect_valid = 1'b0;
        chk("mis_fault_not_yet", {31'b0, fault}, 32'h0);
        tick();
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_halted", {31'b0, halted}, 32'h1);
        chk("mis_valid", {31'b0, ifid_valid}, 32'h0);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("mis_start_ignored", {31'b0, halted}, 32'h1);
        chk("mis_addr_frozen", imem_addr, 32'h42);
        $display("misaligned redirect: fault=%0d", fault);

        // Last legal word, then fall off the end of memory.
        restart();
        redirect_valid = 1'b1; redirect_pc = 32'h3FC; tick();
        redirect_valid = 1'b0; tick();
        chk("last_word_inst", ifid_inst, 32'hfcfd_feff);
        chk("last_word_fault", {31'b0, fault}, 32'h0);
        chk("last_word_pc4", ifid_pc4, 32'h400);
        tick();
        chk("end_fault", {31'b0, fault}, 32'h1);
        chk("end_valid", {31'b0, ifid_valid}, 32'h0);
        $display("fetch past end: fault=%0d", fault);

        // Redirect directly to IMEM_BYTES.
        restart();
        redirect_valid = 1'b1; redirect_pc = 32'h400; tick();
        redirect_valid = 1'b0; tick();
        chk("oob_fault", {31'b0, fault}, 32'h1);
        chk("oob_halted", {31'b0, halted}, 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset("oob_rst");
        $display("redirect to IMEM_BYTES: cleared by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning instruction address width.
REQ-002 SHALL have parameter IWIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 SHALL have parameter IMEM_BYTES, default 1024, meaning instruction memory size in bytes.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a pulse that begins fetching from IDLE.
REQ-008 SHALL have port stall, input, 1, meaning hold the PC and IF/ID register.
REQ-009 SHALL have port flush, input, 1, meaning squash the IF/ID register contents.
REQ-010 SHALL have port redirect_valid, input, 1, meaning a branch or jump target is presented.
REQ-011 SHALL have port redirect_pc, input, AWIDTH, meaning the target byte address.
REQ-012 SHALL have port imem_addr, output, AWIDTH, meaning byte address to the instruction memory, driven combinationally from the PC register.
REQ-013 SHALL have port imem_inst, input, IWIDTH, meaning the big-endian word returned combinationally by memory for imem_addr.
REQ-014 SHALL have ports ifid_valid (1), ifid_pc (AWIDTH), ifid_pc4 (AWIDTH) and ifid_inst (IWIDTH), all outputs, forming the registered IF/ID payload.
REQ-015 SHALL have ports halted (1) and fault (1), both registered outputs.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and HALT.
REQ-017 In IDLE, a start pulse SHALL transition the FSM to RUN; all other inputs SHALL be ignored in IDLE.
REQ-018 In RUN with no redirect, stall or flush, each cycle SHALL load ifid_pc<=pc, ifid_pc4<=pc+4, ifid_inst<=imem_inst and ifid_valid<=1, and SHALL update pc<=pc+4 modulo 2^AWIDTH.
REQ-019 The fetch latency SHALL be one cycle, from pc to a valid IF/ID payload.
REQ-020 Priority in RUN SHALL be redirect > flush > stall > normal.
REQ-021 On redirect, pc SHALL load redirect_pc, ifid_valid SHALL be cleared to 0 and ifid_inst SHALL be set to NOP (0x00000013), even when stall is high.
REQ-022 On flush without redirect, ifid_valid SHALL be cleared to 0, ifid_inst SHALL be set to NOP and pc SHALL advance unless stall is high, in which case pc SHALL hold.
REQ-023 On stall alone, pc and all IF/ID outputs SHALL hold.
REQ-024 A fetch address with pc[1:0]!=0 or pc>IMEM_BYTES-4 SHALL be treated as a fault: the fetch is not loaded into IF/ID, the registers are set to fault<=1, halted<=1 and ifid_valid<=0, and the FSM goes to HALT.
REQ-025 A fault SHALL be evaluated on the PC after the redirect is applied, i.e. on the first cycle that fetches the target.
REQ-026 When an accepted fetch returns EBREAK (0x00100073), it SHALL be loaded into IF/ID as valid; on the next cycle the FSM SHALL enter HALT with halted=1.
REQ-027 In HALT, pc SHALL freeze, ifid_valid SHALL be 0, and only rst SHALL exit HALT.
REQ-028 imem_addr SHALL equal pc in every state.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL set pc=RESET_PC, state=IDLE, ifid_valid=0, ifid_inst=NOP, ifid_pc=0, ifid_pc4=0, halted=0 and fault=0.
REQ-030 rst SHALL override every other input, including mid-redirect and mid-stall.

Structure
REQ-031 The shared package riscv_pkg SHALL hold the NOP and EBREAK constants and the fetch-state enum typedef.
REQ-032 The next-PC mux (redirect, pc+4 or hold) SHALL be the single combinational sub-module fetch_pc_next; all other logic SHALL stay in fetch_unit.

Verification
REQ-033 With rst then start and memory bytes 0..7 = 00 50 00 93 00 10 00 73 -> ifid_inst SHALL be 0x00500093 with ifid_pc=0, then 0x00100073 with ifid_pc=4, and halted SHALL be 1 one cycle later.
REQ-034 With stall high for 3 cycles at pc=8 -> imem_addr SHALL stay 8 and ifid_pc/ifid_inst SHALL stay unchanged; after release, ifid_pc SHALL be 8.
REQ-035 With redirect_valid and redirect_pc=0x40 together with stall=1 -> next cycle pc SHALL be 0x40 and ifid_valid SHALL be 0; the following cycle ifid_pc SHALL be 0x40.
REQ-036 With redirect_pc=0x42, or redirect_pc=IMEM_BYTES -> fault SHALL be 1, halted SHALL be 1 and ifid_valid SHALL be 0; start SHALL then be ignored until rst.
REQ-037 With flush and stall together at pc=0x10 -> ifid_valid SHALL be 0 and ifid_inst SHALL be 0x00000013, with pc held at 0x10.
REQ-038 With rst asserted in RUN at pc=0x20 -> the next cycle SHALL show pc=RESET_PC, state IDLE and all outputs at their reset values.
